fixed_accumulating_dot_product: RTL and testbench

- Signed fixed-point dot product over long vectors, supplied as a stream of IN_SIZE-element beats.
- Each beat is multiplied element-wise, reduced through a registered adder tree, and added into an accumulator.
- One result is emitted every NUM_BEATS accepted beats.
- Successor to the single-beat dot product; used in linear layers where the input feature count exceeds the parallel block size.

---
 rtl/fixed_accumulating_dot_product.sv | 170 +++++++++++++++++
 tb/tb_fixed_accumulating_dot_product.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_accumulating_dot_product.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_accumulating_dot_product                                           |
// | Signed fixed-point dot product over NUM_BEATS streamed IN_SIZE beats.    |
// | Optional macro FIXED_ACC_DOT_PRODUCT_SATURATE_EN: saturating narrowing   |
// | plus sat_flag output (wrap-around truncation when undefined).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fixed_accumulating_dot_product #(
  parameter int IN_WIDTH     = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IN_SIZE      = 4,
  parameter int NUM_BEATS    = 2,
  parameter int ACC_WIDTH    = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE * NUM_BEATS),
  parameter int OUT_WIDTH    = ACC_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]   data_in,
  input  logic                               data_in_valid,
  output logic                               data_in_ready,
  input  logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0] weight,
  input  logic                               weight_valid,
  output logic                               weight_ready,
  output logic [OUT_WIDTH-1:0]               data_out,
  output logic                               data_out_valid,
  input  logic                               data_out_ready,
  output logic [$clog2(NUM_BEATS):0]         beat_count
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
  ,
  output logic                               sat_flag
`endif
);

  localparam int c_prod_w = IN_WIDTH + WEIGHT_WIDTH;
  localparam int c_cnt_w  = $clog2(NUM_BEATS) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_BEATS - 1);

  logic                              w_adv;
  logic                              w_accept;
  logic [c_cnt_w-1:0]                r_cnt;

  logic [IN_SIZE-1:0][c_prod_w-1:0]  r_prod;
  logic                              r_s1_valid, r_s1_first, r_s1_last;
  logic [ACC_WIDTH-1:0]              w_tree;
  logic [ACC_WIDTH-1:0]              r_s2_sum;
  logic                              r_s2_valid, r_s2_first, r_s2_last;
  logic [ACC_WIDTH-1:0]              r_acc;
  logic [ACC_WIDTH-1:0]              w_result;
  logic                              w_emit;
  logic [OUT_WIDTH-1:0]              w_out;

  // Whole pipeline freezes only when a finished result is waiting on downstream.
  assign w_adv         = !(data_out_valid && !data_out_ready);
  assign w_accept      = data_in_valid && weight_valid && w_adv;
  assign data_in_ready = w_accept;
  assign weight_ready  = w_accept;
  assign beat_count    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_prod     <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      r_s1_first <= (r_cnt == '0);
      r_s1_last  <= (r_cnt == c_last);
      for (int i = 0; i < IN_SIZE; i++) begin
        r_prod[i] <= c_prod_w'($signed(data_in[i])) * c_prod_w'($signed(weight[i]));
      end
    end
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      w_tree = w_tree + ACC_WIDTH'($signed(r_prod[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_sum   <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_sum   <= w_tree;
    end
  end

  // First beat ignores the accumulator, so a clear on the previous last beat never collides.
  assign w_result = r_s2_first ? r_s2_sum : r_acc + r_s2_sum;
  assign w_emit   = r_s2_valid && r_s2_last;

`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
  logic w_clip;
`endif

  generate
    if (OUT_WIDTH < ACC_WIDTH) begin : g_narrow
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
      logic [ACC_WIDTH-OUT_WIDTH:0] w_top;
      assign w_top  = w_result[ACC_WIDTH-1:OUT_WIDTH-1];
      assign w_clip = !((&w_top) || !(|w_top));
      always_comb begin
        w_out = w_result[OUT_WIDTH-1:0];
        if (w_clip) begin
          w_out = w_result[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
      end
`else
      logic w_unused_hi;
      assign w_unused_hi = ^w_result[ACC_WIDTH-1:OUT_WIDTH];
      assign w_out       = w_result[OUT_WIDTH-1:0];
`endif
    end else begin : g_full
      assign w_out = w_result[OUT_WIDTH-1:0];
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
      assign w_clip = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_adv && r_s2_valid) begin
      r_acc <= r_s2_last ? '0 : w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (w_adv) begin
      data_out_valid <= w_emit;
      if (w_emit) begin
        data_out <= w_out;
      end
    end
  end

`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (w_adv) begin
      sat_flag <= w_emit && w_clip;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fixed_accumulating_dot_product.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fixed_accumulating_dot_product                                        |
// | Randomised + directed bench with a vector-level scoreboard.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fixed_accumulating_dot_product;

  localparam int NB = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][7:0] data_in, weight;
  logic            data_in_valid, weight_valid, data_out_ready;
  logic            data_in_ready, weight_ready, data_out_valid;
  logic [18:0]     data_out;
  logic [1:0]      beat_count;
  logic            rdy8_d, rdy8_w, dval8;
  logic [7:0]      dout8;
  logic [1:0]      bc8;
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
  logic            sat8, sat_full;
`endif

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp_q[$];
  int     m_idx  = 0;
  longint m_part = 0;
  bit     m_adv;

  always #5 clk = ~clk;

  fixed_accumulating_dot_product dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .beat_count(beat_count)
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
    , .sat_flag(sat_full)
`endif
  );

  fixed_accumulating_dot_product #(.OUT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy8_d),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(rdy8_w),
    .data_out(dout8), .data_out_valid(dval8), .data_out_ready(data_out_ready),
    .beat_count(bc8)
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
    , .sat_flag(sat8)
`endif
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected 8-bit output for a full-precision result.
  function automatic longint narrow8(input longint e);
    logic signed [7:0] t;
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
    if (e > 127) return 127;
    if (e < -128) return -128;
    return e;
`else
    t = e[7:0];
    return longint'(t);
`endif
  endfunction

  // Scoreboard: full vectors become one expected result each.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_idx  = 0;
      m_part = 0;
    end else begin
      m_adv = !(data_out_valid && !data_out_ready);
      check_eq("in_ready", longint'(data_in_ready), longint'(data_in_valid && weight_valid && m_adv));
      check_eq("w_ready", longint'(weight_ready), longint'(data_in_valid && weight_valid && m_adv));
      check_eq("beat_count", longint'(beat_count), longint'(m_idx));
      if (data_out_valid) begin
        check_eq("out_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check_eq("data_out", longint'($signed(data_out)), exp_q[0]);
          check_eq("data_out8", longint'($signed(dout8)), narrow8(exp_q[0]));
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
          check_eq("sat_flag", longint'(sat8), longint'(exp_q[0] > 127 || exp_q[0] < -128));
`endif
          if (data_out_ready) void'(exp_q.pop_front());
        end
      end
      if (data_in_valid && weight_valid && data_in_ready) begin
        for (int i = 0; i < 4; i++)
          m_part += longint'($signed(data_in[i])) * longint'($signed(weight[i]));
        m_idx++;
        if (m_idx == NB) begin
          exp_q.push_back(m_part);
          m_idx  = 0;
          m_part = 0;
        end
      end
    end
  end

  task automatic send_beat(input logic [3:0][7:0] d, input logic [3:0][7:0] w);
    bit ok;
    ok = 0;
    data_in = d; weight = w; data_in_valid = 1; weight_valid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_in_ready) begin ok = 1; break; end
    end
    check_eq("accept", longint'(ok), 1);
    @(posedge clk); #1;
    data_in_valid = 0; weight_valid = 0;
  endtask

  task automatic wait_out(input string tag, input longint exp);
    bit seen;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (data_out_valid) seen = 1;
    end
    check_eq({tag, "_seen"}, longint'(seen), 1);
    if (seen) check_eq(tag, longint'($signed(data_out)), exp);
  endtask

  task automatic drain();
    data_in_valid = 0; weight_valid = 0; data_out_ready = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !data_out_valid) break;
    end
    check_eq("drained", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    bit took;
    rst = 1; data_in = '0; weight = '0;
    data_in_valid = 0; weight_valid = 0; data_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data_out", longint'(data_out), 0);
    check_eq("rst_valid", longint'(data_out_valid), 0);
    check_eq("rst_beat_count", longint'(beat_count), 0);
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
    check_eq("rst_sat_flag", longint'(sat8), 0);
`endif
    rst = 0;
    @(posedge clk); #1;

    // Basic + latency
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1});
    send_beat({8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'd1, 8'd1, 8'd1, 8'd1});
    check_eq("lat_t1", longint'(data_out_valid), 0);
    @(posedge clk); #1;
    check_eq("lat_t2", longint'(data_out_valid), 0);
    @(posedge clk); #1;
    check_eq("lat_t3", longint'(data_out_valid), 1);
    check_eq("basic", longint'($signed(data_out)), 6);
    drain();

    // Extremes
    send_beat({4{8'h80}}, {4{8'h80}});
    send_beat({4{8'h80}}, {4{8'h80}});
    wait_out("extreme", 131072);
    drain();

    // Backpressure across three back-to-back vectors
    data_out_ready = 0;
    fork
      begin
        for (int v = 0; v < 6; v++) send_beat({4{8'(v + 1)}}, {8'd1, 8'd2, 8'hFE, 8'(v)});
      end
      begin
        for (int k = 0; k < 50 && !data_out_valid; k++) begin @(posedge clk); #1; end
        check_eq("bp_out_seen", longint'(data_out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_stall_ready", longint'(data_in_ready), 0);
        end
        @(posedge clk); #1;
        data_out_ready = 1;
      end
    join
    drain();

    // Join skew: weight arrives two cycles late
    data_in = {4{8'd1}}; weight = {4{8'd1}}; data_in_valid = 1; weight_valid = 0;
    repeat (2) begin
      @(negedge clk);
      check_eq("skew_ready", longint'(data_in_ready), 0);
      check_eq("skew_count", longint'(beat_count), 0);
    end
    @(posedge clk); #1;
    send_beat({4{8'd1}}, {4{8'd1}});
    send_beat({4{8'd1}}, {4{8'd2}});
    wait_out("skew", 12);
    drain();

    // Reset mid-vector discards the partial sum
    send_beat({4{8'd10}}, {4{8'd1}});
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_eq("midrst_count", longint'(beat_count), 0);
    send_beat({4{8'd1}}, {4{8'd1}});
    send_beat({4{8'd1}}, {4{8'd1}});
    wait_out("midrst", 8);
    drain();

    // Narrow output: 300 wraps to 44 or clips to 127
    send_beat({8'd0, 8'd0, 8'd50, 8'd100}, {8'd1, 8'd1, 8'd2, 8'd1});
    send_beat({8'd0, 8'd0, 8'd50, 8'd50}, {4{8'd1}});
    wait_out("full300", 300);
`ifdef FIXED_ACC_DOT_PRODUCT_SATURATE_EN
    check_eq("narrow300", longint'($signed(dout8)), 127);
    check_eq("sat300", longint'(sat8), 1);
`else
    check_eq("narrow300", longint'($signed(dout8)), 44);
`endif
    drain();

    // Random streaming with random backpressure and skewed valids
    for (int i = 0; i < 4; i++) begin
      data_in[i] = 8'($urandom_range(0, 255)); weight[i] = 8'($urandom_range(0, 255));
    end
    data_in_valid = ($urandom_range(0, 3) != 0);
    weight_valid  = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 600; c++) begin
      data_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = data_in_ready;
      @(posedge clk); #1;
      if (took) begin
        for (int i = 0; i < 4; i++) begin
          data_in[i] = 8'($urandom_range(0, 255)); weight[i] = 8'($urandom_range(0, 255));
        end
        data_in_valid = ($urandom_range(0, 3) != 0);
        weight_valid  = ($urandom_range(0, 3) != 0);
      end else begin
        if (!data_in_valid) data_in_valid = 1'($urandom_range(0, 1));
        if (!weight_valid)  weight_valid  = 1'($urandom_range(0, 1));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
